pipeline_trace_buffer: RTL and testbench

- Synthesizable on-chip trace capture unit for the 5-stage MIPS pipeline. It replaces ad-hoc test_* port observation with a triggered circular buffer.
- Samples NUM_CH probe channels (e.g. PC_IF, instruction_IF_ID, alu_result_EX, mux_wb_data_WB) every valid cycle.
- Freezes on a programmable trigger plus a post-trigger count, then streams the captured window out oldest-first over a valid/ready port.

---
 rtl/pipeline_trace_buffer.sv | 239 +++++++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// Triggered circular trace buffer for the 5-stage MIPS pipeline probes.
// Captures NUM_CH probe channels on every valid cycle while armed, freezes
// after a programmable trigger plus post-trigger count, then streams the
// captured window oldest-first over a valid/ready port.
module pipeline_trace_buffer #(
  parameter int CH_WIDTH = 32,
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*CH_WIDTH-1:0] probe_data,
  input  logic                       probe_valid,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [1:0]                 trig_mode,
  input  logic [CH_WIDTH-1:0]        trig_value,
  input  logic [CH_WIDTH-1:0]        trig_mask,
  input  logic [ADDR_W-1:0]          post_count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NUM_CH*CH_WIDTH-1:0] rd_data,
  output logic                       rd_last,
  output logic [ADDR_W-1:0]          trig_index,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int ENTRY_W = NUM_CH * CH_WIDTH;

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W-1:0] PTR_ZERO  = 0;
  localparam logic [ADDR_W:0]   FILL_ONE  = 1;
  localparam logic [ADDR_W:0]   FILL_TWO  = 2;
  localparam logic [ADDR_W:0]   FILL_ZERO = 0;
  localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_READ  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       fill_q, fill_d;
  logic [ADDR_W-1:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       remaining_q, remaining_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [ENTRY_W-1:0]    rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]     trig_index_q, trig_index_d;
  logic                  done_q, done_d;

  // Trigger configuration captured at arm time
  logic [1:0]            trig_mode_q, trig_mode_d;
  logic [CH_WIDTH-1:0]   trig_value_q, trig_value_d;
  logic [CH_WIDTH-1:0]   trig_mask_q, trig_mask_d;
  logic [ADDR_W-1:0]     post_count_q, post_count_d;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic                  mem_we;

  logic                  match;
  logic                  hit;
  logic [ADDR_W-1:0]     wr_ptr_inc;
  logic [ADDR_W:0]       fill_inc;
  logic [ADDR_W-1:0]     rd_start;
  logic [ADDR_W-1:0]     trig_idx_new;
  logic                  enter_read;

  // Trigger compare on channel 0 and pointer arithmetic for the write in flight
  always_comb begin
    match        = ((probe_data[CH_WIDTH-1:0] & trig_mask_q) == (trig_value_q & trig_mask_q));
    case (trig_mode_q)
      2'b00:   hit = 1'b1;
      2'b10:   hit = !match;
      default: hit = match;
    endcase
    wr_ptr_inc   = wr_ptr_q + PTR_ONE;
    fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
    // Oldest entry of the window once the current sample is written; a full
    // buffer truncates fill to 0 so the start lands on the new wr_ptr.
    rd_start     = wr_ptr_inc - fill_inc[ADDR_W-1:0];
    trig_idx_new = fill_inc[ADDR_W-1:0] - PTR_ONE - post_count_q;
  end

  // Next-state and datapath control for capture and readout
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    post_cnt_d   = post_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    remaining_d  = remaining_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data_d    = rd_data_q;
    trig_index_d = trig_index_q;
    done_d       = 1'b0;
    trig_mode_d  = trig_mode_q;
    trig_value_d = trig_value_q;
    trig_mask_d  = trig_mask_q;
    post_count_d = post_count_q;
    mem_we       = 1'b0;
    enter_read   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!abort && arm) begin
          state_d      = ST_ARMED;
          wr_ptr_d     = PTR_ZERO;
          fill_d       = FILL_ZERO;
          trig_mode_d  = trig_mode;
          trig_value_d = trig_value;
          trig_mask_d  = trig_mask;
          post_count_d = post_count;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (probe_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          fill_d   = fill_inc;
          if (hit) begin
            if (post_count_q == PTR_ZERO) begin
              enter_read = 1'b1;
            end else begin
              post_cnt_d = post_count_q;
              state_d    = ST_POST;
            end
          end
        end
      end
      ST_POST: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (probe_valid) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_inc;
          fill_d     = fill_inc;
          post_cnt_d = post_cnt_q - PTR_ONE;
          if (post_cnt_q == PTR_ONE) begin
            enter_read = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d    = ST_IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else if (rd_valid_q && rd_ready) begin
          remaining_d = remaining_q - FILL_ONE;
          if (rd_last_q) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            done_d     = 1'b1;
          end else begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_last_d = (remaining_q == FILL_TWO);
            rd_data_d = mem_q[rd_ptr_q + PTR_ONE];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The final write and the first readout fetch share a cycle; when the
    // window's oldest entry is the one being written, bypass the memory.
    if (enter_read) begin
      state_d      = ST_READ;
      rd_ptr_d     = rd_start;
      remaining_d  = fill_inc;
      rd_valid_d   = 1'b1;
      rd_last_d    = (fill_inc == FILL_ONE);
      trig_index_d = trig_idx_new;
      rd_data_d    = (rd_start == wr_ptr_q) ? probe_data : mem_q[rd_start];
    end
  end

  // Control and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      post_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      remaining_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
      trig_index_q <= '0;
      done_q       <= 1'b0;
      trig_mode_q  <= '0;
      trig_value_q <= '0;
      trig_mask_q  <= '0;
      post_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      post_cnt_q   <= post_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      remaining_q  <= remaining_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
      trig_index_q <= trig_index_d;
      done_q       <= done_d;
      trig_mode_q  <= trig_mode_d;
      trig_value_q <= trig_value_d;
      trig_mask_q  <= trig_mask_d;
      post_count_q <= post_count_d;
    end
  end

  // Trace storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= probe_data;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign rd_data    = rd_data_q;
  assign trig_index = trig_index_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed testbench for pipeline_trace_buffer.
module tb_pipeline_trace_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] probe_data;
  logic         probe_valid;
  logic         arm;
  logic         abort;
  logic [1:0]   trig_mode;
  logic [31:0]  trig_value;
  logic [31:0]  trig_mask;
  logic [3:0]   post_count;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] rd_data;
  logic         rd_last;
  logic [3:0]   trig_index;
  logic [1:0]   state;
  logic         done;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] expq [$];
  bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] s3d [9] = '{32'h40, 32'h51, 32'h42, 32'h51, 32'h45, 32'h51, 32'h46, 32'h51, 32'h48};
  bit          s3v [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  s3s [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};

  pipeline_trace_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .probe_data  (probe_data),
    .probe_valid (probe_valid),
    .arm         (arm),
    .abort       (abort),
    .trig_mode   (trig_mode),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .post_count  (post_count),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .trig_index  (trig_index),
    .state       (state),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Channel 0 carries v; other channels are distinct functions of v
  function automatic logic [127:0] mk(input logic [31:0] v);
    return {v ^ 32'hDEAD_0000, v + 32'h0000_1000, ~v, v};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drain the readout against expq; rmode 0 = always ready, 1 = stall pattern
  task automatic read_all(input int rmode);
    int   idx;
    int   k;
    int   n;
    bit   rdy;
    logic vnow;
    idx = 0;
    k   = 0;
    n   = expq.size();
    while (idx < n && k < 200) begin
      vnow = rd_valid;
      if (vnow) begin
        chk("rd_data", rd_data, mk(expq[idx]));
        chk("rd_last", {127'b0, rd_last}, {127'b0, (idx == n - 1)});
        chk("done_low", {127'b0, done}, 128'd0);
      end
      rdy      = (rmode == 0) ? 1'b1 : pat[k % 7];
      rd_ready = rdy;
      step;
      if (vnow && rdy) idx++;
      k++;
    end
    chk("read_count", idx, n);
    rd_ready = 1'b0;
    chk("post_read_valid", {127'b0, rd_valid}, 128'd0);
    chk("done_pulse", {127'b0, done}, 128'd1);
    chk("post_read_state", {126'b0, state}, 128'd0);
    step;
    chk("done_clear", {127'b0, done}, 128'd0);
  endtask

  initial begin
    int v;
    reset       = 1'b0;
    probe_data  = '0;
    probe_valid = 1'b0;
    arm         = 1'b0;
    abort       = 1'b0;
    trig_mode   = 2'b00;
    trig_value  = '0;
    trig_mask   = '0;
    post_count  = '0;
    rd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {126'b0, state}, 128'd0);
    chk("rst_rd_valid", {127'b0, rd_valid}, 128'd0);
    chk("rst_rd_last", {127'b0, rd_last}, 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    chk("rst_trig_index", {124'b0, trig_index}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    reset = 1'b1;
    step;

    // Immediate trigger, post_count 3
    trig_mode   = 2'b00;
    post_count  = 4'd3;
    arm         = 1'b1;
    probe_valid = 1'b1;
    probe_data  = mk(32'h0F);
    step;
    chk("s1_armed", {126'b0, state}, 128'd1);
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe_data = mk(32'h10 + i);
      step;
      chk("s1_state", {126'b0, state}, (i == 3) ? 128'd3 : 128'd2);
    end
    probe_valid = 1'b0;
    chk("s1_rd_valid", {127'b0, rd_valid}, 128'd1);
    chk("s1_trig_index", {124'b0, trig_index}, 128'd0);
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back(32'h10 + i);
    read_all(0);

    // Equal trigger with wrap, config changed after arm, backpressured readout
    trig_mode  = 2'b01;
    trig_value = 32'h20;
    trig_mask  = 32'hFFFF_FFFF;
    post_count = 4'd5;
    arm        = 1'b1;
    step;
    chk("s2_armed", {126'b0, state}, 128'd1);
    arm         = 1'b0;
    trig_value  = 32'h5;
    trig_mask   = 32'h0;
    post_count  = 4'd0;
    probe_valid = 1'b1;
    for (v = 0; v < 60; v++) begin
      probe_data = mk(v);
      step;
      if (state == 2'b11) break;
    end
    chk("s2_last_sample", v, 32'h25);
    chk("s2_trig_index", {124'b0, trig_index}, 128'd10);
    probe_data = mk(32'h0BAD);
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(32'h16 + i);
    read_all(1);
    probe_valid = 1'b0;

    // Not-equal mode with gaps in probe_valid
    trig_mode  = 2'b10;
    trig_value = 32'h0;
    trig_mask  = 32'h1;
    post_count = 4'd2;
    arm        = 1'b1;
    step;
    arm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      probe_data  = mk(s3d[i]);
      probe_valid = s3v[i];
      step;
      chk("s3_state", {126'b0, state}, {126'b0, s3s[i]});
    end
    probe_valid = 1'b0;
    chk("s3_trig_index", {124'b0, trig_index}, 128'd2);
    expq.delete();
    expq.push_back(32'h40);
    expq.push_back(32'h42);
    expq.push_back(32'h45);
    expq.push_back(32'h46);
    expq.push_back(32'h48);
    read_all(0);

    // Reset in POST with post_cnt at 3, then single-entry capture
    trig_mode  = 2'b00;
    post_count = 4'd5;
    arm        = 1'b1;
    step;
    arm         = 1'b0;
    probe_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe_data = mk(32'h60 + i);
      step;
    end
    chk("s5_in_post", {126'b0, state}, 128'd2);
    reset = 1'b0;
    #2;
    chk("s5_rst_state", {126'b0, state}, 128'd0);
    chk("s5_rst_rd_valid", {127'b0, rd_valid}, 128'd0);
    chk("s5_rst_rd_last", {127'b0, rd_last}, 128'd0);
    chk("s5_rst_rd_data", rd_data, 128'd0);
    chk("s5_rst_trig_index", {124'b0, trig_index}, 128'd0);
    chk("s5_rst_done", {127'b0, done}, 128'd0);
    reset       = 1'b1;
    probe_valid = 1'b0;
    post_count  = 4'd0;
    arm         = 1'b1;
    step;
    chk("s5_armed", {126'b0, state}, 128'd1);
    arm         = 1'b0;
    probe_valid = 1'b1;
    probe_data  = mk(32'h77);
    step;
    probe_valid = 1'b0;
    chk("s5_read", {126'b0, state}, 128'd3);
    chk("s5_rd_valid", {127'b0, rd_valid}, 128'd1);
    chk("s5_trig_index", {124'b0, trig_index}, 128'd0);
    expq.delete();
    expq.push_back(32'h77);
    read_all(0);

    // Abort in ARMED after 7 samples, abort beating a same-cycle trigger
    trig_mode  = 2'b01;
    trig_value = 32'hCAFE;
    trig_mask  = 32'hFFFF_FFFF;
    post_count = 4'd2;
    arm        = 1'b1;
    step;
    arm         = 1'b0;
    probe_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      probe_data = mk(i);
      step;
    end
    chk("s6_still_armed", {126'b0, state}, 128'd1);
    probe_data = mk(32'hCAFE);
    abort      = 1'b1;
    step;
    abort = 1'b0;
    chk("s6_abort_state", {126'b0, state}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      chk("s6_rd_valid", {127'b0, rd_valid}, 128'd0);
      chk("s6_done", {127'b0, done}, 128'd0);
      chk("s6_idle", {126'b0, state}, 128'd0);
      step;
    end
    arm   = 1'b1;
    abort = 1'b1;
    step;
    chk("s6_arm_abort", {126'b0, state}, 128'd0);
    arm   = 1'b0;
    abort = 1'b0;
    step;
    chk("s6_stay_idle", {126'b0, state}, 128'd0);
    chk("s6_final_valid", {127'b0, rd_valid}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
